// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types: default field widths, request payload and arbiter state encoding.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned ID_W   = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              write;
    logic [ID_W-1:0]   id;
  } mem_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority encoder: first asserted request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_MASTERS = 4,
  localparam int unsigned PTR_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [PTR_W-1:0]       i_ptr,
  input  logic                   i_enable,
  output logic [NUM_MASTERS-1:0] o_gnt_c,
  output logic [PTR_W-1:0]       o_gnt_idx_c,
  output logic                   o_gnt_valid_c
);

  int unsigned w_idx;

  // Walk the masters in priority order starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt_c       = '0;
    o_gnt_idx_c   = '0;
    o_gnt_valid_c = 1'b0;
    w_idx         = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= NUM_MASTERS) w_idx = w_idx - NUM_MASTERS;
      if (i_enable && !o_gnt_valid_c && i_req[PTR_W'(w_idx)]) begin
        o_gnt_valid_c             = 1'b1;
        o_gnt_idx_c               = PTR_W'(w_idx);
        o_gnt_c[PTR_W'(w_idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory slave among NUM_MASTERS masters, with ID-based
// response routing back to the originating master.
module memory_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = ADDR_W,
  parameter int unsigned DATA_WIDTH  = DATA_W,
  parameter int unsigned ID_WIDTH    = ID_W
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  output logic [NUM_MASTERS-1:0]            m_taken,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data,
  input  logic [NUM_MASTERS-1:0]            m_write,
  output logic                              s_valid,
  input  logic                              s_taken,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic [DATA_WIDTH-1:0]             s_data,
  output logic                              s_write,
  output logic [ID_WIDTH-1:0]               s_id,
  input  logic                              r_valid_in,
  input  logic [ID_WIDTH-1:0]               r_id_in,
  input  logic [DATA_WIDTH-1:0]             r_data_in,
  output logic                              r_taken_out,
  output logic [NUM_MASTERS-1:0]            r_valid,
  output logic [DATA_WIDTH-1:0]             r_data,
  input  logic [NUM_MASTERS-1:0]            r_taken,
  output logic                              bad_id
);

  localparam int unsigned PTR_W = $clog2(NUM_MASTERS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic                  write;
    logic [ID_WIDTH-1:0]   id;
  } slot_t;

  arb_state_t             r_state, w_state_next;
  logic [PTR_W-1:0]       r_ptr, w_ptr_next;
  slot_t                  r_slot, w_slot_next;
  logic                   r_bad_id;

  logic [NUM_MASTERS-1:0] w_gnt;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic                   w_gnt_valid;
  logic                   w_arb_en;
  logic                   w_id_ok;

  logic [ADDR_WIDTH-1:0]  w_addr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  w_data_arr [NUM_MASTERS];

  // Unpack the flat per-master buses so the grant index can select a lane directly.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign w_addr_arr[gi] = m_address[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data_arr[gi] = m_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_arb_en = (r_state == IDLE) && !reset;

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr_arbiter (
    .i_req         (m_valid),
    .i_ptr         (r_ptr),
    .i_enable      (w_arb_en),
    .o_gnt_c       (w_gnt),
    .o_gnt_idx_c   (w_gnt_idx),
    .o_gnt_valid_c (w_gnt_valid)
  );

  assign m_taken = w_gnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_slot   <= '0;
      r_bad_id <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_slot   <= w_slot_next;
      if (r_valid_in && !w_id_ok) r_bad_id <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_slot_next  = r_slot;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_next        = ISSUE;
          w_ptr_next          = (w_gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
          w_slot_next.address = w_addr_arr[w_gnt_idx];
          w_slot_next.data    = w_data_arr[w_gnt_idx];
          w_slot_next.write   = m_write[w_gnt_idx];
          w_slot_next.id      = ID_WIDTH'(w_gnt_idx);
        end
      end
      ISSUE: begin
        if (s_taken) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign s_valid   = (r_state == ISSUE);
  assign s_address = r_slot.address;
  assign s_data    = r_slot.data;
  assign s_write   = r_slot.write;
  assign s_id      = r_slot.id;

  // Response path: decode ID to a master lane; out-of-range IDs are swallowed and flagged.
  assign w_id_ok = (r_id_in < ID_WIDTH'(NUM_MASTERS));

  always_comb begin
    r_valid = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      r_valid[i] = r_valid_in && (r_id_in == ID_WIDTH'(i));
    end
  end

  assign r_data      = r_data_in;
  assign r_taken_out = w_id_ok ? r_taken[PTR_W'(r_id_in)] : 1'b1;
  assign bad_id      = r_bad_id;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed self-checking bench for memory_bus_arbiter: scoreboarded issue slots,
// round-robin order, slave stall, response routing, bad ID and reset during issue.
module tb_memory_bus_arbiter;

  typedef struct packed {
    logic [23:0] address;
    logic [23:0] data;
    logic        write;
    logic [7:0]  id;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [3:0]  m_valid;
  logic [3:0]  m_taken;
  logic [95:0] m_address;
  logic [95:0] m_data;
  logic [3:0]  m_write;
  logic        s_valid;
  logic        s_taken;
  logic [23:0] s_address;
  logic [23:0] s_data;
  logic        s_write;
  logic [7:0]  s_id;
  logic        r_valid_in;
  logic [7:0]  r_id_in;
  logic [23:0] r_data_in;
  logic        r_taken_out;
  logic [3:0]  r_valid;
  logic [23:0] r_data;
  logic [3:0]  r_taken;
  logic        bad_id;

  logic [23:0] ma [4];
  logic [23:0] md [4];
  logic        mw [4];

  exp_t sb [$];
  exp_t cur;
  int   vectors;
  int   miscompares;

  memory_bus_arbiter #(
    .NUM_MASTERS (4),
    .ADDR_WIDTH  (24),
    .DATA_WIDTH  (24),
    .ID_WIDTH    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .m_valid     (m_valid),
    .m_taken     (m_taken),
    .m_address   (m_address),
    .m_data      (m_data),
    .m_write     (m_write),
    .s_valid     (s_valid),
    .s_taken     (s_taken),
    .s_address   (s_address),
    .s_data      (s_data),
    .s_write     (s_write),
    .s_id        (s_id),
    .r_valid_in  (r_valid_in),
    .r_id_in     (r_id_in),
    .r_data_in   (r_data_in),
    .r_taken_out (r_taken_out),
    .r_valid     (r_valid),
    .r_data      (r_data),
    .r_taken     (r_taken),
    .bad_id      (bad_id)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_pack
    assign m_address[gi*24 +: 24] = ma[gi];
    assign m_data[gi*24 +: 24]    = md[gi];
    assign m_write[gi]            = mw[gi];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request vector in IDLE and expect master g to win; record the slot it should issue.
  task automatic do_grant(input logic [3:0] vld, input int g);
    logic [3:0] e;
    exp_t       x;
    e      = '0;
    e[g]   = 1'b1;
    m_valid = vld;
    @(negedge clock);
    chk("s_valid_idle", 64'(s_valid), 64'(0));
    chk("m_taken_grant", 64'(m_taken), 64'(e));
    x.address = ma[g];
    x.data    = md[g];
    x.write   = mw[g];
    x.id      = 8'(g);
    sb.push_back(x);
    tick();
  endtask

  // In ISSUE: compare the presented slot against the oldest expected one.
  task automatic check_slot();
    @(negedge clock);
    chk("s_valid_issue", 64'(s_valid), 64'(1));
    chk("m_taken_issue", 64'(m_taken), 64'(0));
    chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      chk("s_address", 64'(s_address), 64'(cur.address));
      chk("s_data", 64'(s_data), 64'(cur.data));
      chk("s_write", 64'(s_write), 64'(cur.write));
      chk("s_id", 64'(s_id), 64'(cur.id));
    end
  endtask

  task automatic check_issue(input int stall);
    check_slot();
    for (int i = 0; i < stall; i++) begin
      tick();
      @(negedge clock);
      chk("stall_s_valid", 64'(s_valid), 64'(1));
      chk("stall_s_address", 64'(s_address), 64'(cur.address));
      chk("stall_s_id", 64'(s_id), 64'(cur.id));
      chk("stall_m_taken", 64'(m_taken), 64'(0));
    end
    s_taken = 1'b1;
    tick();
    s_taken = 1'b0;
    #3;
    chk("s_valid_drop", 64'(s_valid), 64'(0));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ma[0] = 24'h000100; md[0] = 24'hABCDEF; mw[0] = 1'b1;
    ma[1] = 24'h000204; md[1] = 24'h111111; mw[1] = 1'b0;
    ma[2] = 24'h0003F8; md[2] = 24'h2A2A2A; mw[2] = 1'b1;
    ma[3] = 24'hFFFFFC; md[3] = 24'h5C5C5C; mw[3] = 1'b0;
    reset      = 1'b1;
    m_valid    = 4'b0001;
    s_taken    = 1'b0;
    r_valid_in = 1'b0;
    r_id_in    = 8'd0;
    r_data_in  = 24'h0;
    r_taken    = 4'b0000;
    tick();
    tick();

    // Reset state, with a request pending that must not be taken.
    @(negedge clock);
    chk("rst_m_taken", 64'(m_taken), 64'(0));
    chk("rst_s_valid", 64'(s_valid), 64'(0));
    chk("rst_s_address", 64'(s_address), 64'(0));
    chk("rst_s_id", 64'(s_id), 64'(0));
    chk("rst_bad_id", 64'(bad_id), 64'(0));
    m_valid = 4'b0000;
    tick();
    reset = 1'b0;

    // Single request from master 0.
    do_grant(4'b0001, 0);
    m_valid = 4'b0000;
    check_issue(0);

    // Re-centre the pointer, then round-robin with every master requesting.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_grant(4'b1111, 0);
    check_issue(0);
    do_grant(4'b1111, 1);
    check_issue(0);
    do_grant(4'b1111, 2);
    check_issue(0);
    do_grant(4'b1111, 3);
    check_issue(0);
    do_grant(4'b1111, 0);
    check_issue(0);

    // Slave stall with other masters still requesting.
    do_grant(4'b1110, 1);
    check_issue(5);
    do_grant(4'b1100, 2);
    m_valid = 4'b0000;
    check_issue(0);

    // Response routing to master 2.
    r_valid_in = 1'b1;
    r_id_in    = 8'd2;
    r_data_in  = 24'h123456;
    r_taken    = 4'b0000;
    @(negedge clock);
    chk("rsp_r_valid", 64'(r_valid), 64'(4'b0100));
    chk("rsp_r_data", 64'(r_data), 64'(24'h123456));
    chk("rsp_taken_none", 64'(r_taken_out), 64'(0));
    r_taken = 4'b1011;
    #1;
    chk("rsp_taken_other", 64'(r_taken_out), 64'(0));
    r_taken = 4'b0100;
    #1;
    chk("rsp_taken_own", 64'(r_taken_out), 64'(1));
    tick();
    r_valid_in = 1'b0;
    r_taken    = 4'b0000;

    // Out-of-range ID without valid must not set the flag.
    r_id_in = 8'd4;
    @(negedge clock);
    chk("id4_r_valid", 64'(r_valid), 64'(0));
    chk("id4_taken_out", 64'(r_taken_out), 64'(1));
    tick();
    @(negedge clock);
    chk("id4_no_bad_id", 64'(bad_id), 64'(0));

    // Bad ID with valid: dropped, flag sets on the edge and sticks.
    r_valid_in = 1'b1;
    r_id_in    = 8'd9;
    r_data_in  = 24'h0F0F0F;
    #1;
    chk("bad_r_valid", 64'(r_valid), 64'(0));
    chk("bad_taken_out", 64'(r_taken_out), 64'(1));
    chk("bad_id_before_edge", 64'(bad_id), 64'(0));
    tick();
    r_valid_in = 1'b0;
    r_id_in    = 8'd0;
    @(negedge clock);
    chk("bad_id_set", 64'(bad_id), 64'(1));
    tick();
    tick();
    @(negedge clock);
    chk("bad_id_sticky", 64'(bad_id), 64'(1));
    tick();

    // Reset while a request is being issued; pointer is 3 here so master 0 wins by wrap.
    do_grant(4'b0001, 0);
    m_valid = 4'b0000;
    check_slot();
    reset   = 1'b1;
    m_valid = 4'b1000;
    tick();
    @(negedge clock);
    chk("midrst_s_valid", 64'(s_valid), 64'(0));
    chk("midrst_m_taken", 64'(m_taken), 64'(0));
    chk("midrst_bad_id", 64'(bad_id), 64'(0));
    tick();
    reset = 1'b0;
    do_grant(4'b1000, 3);
    m_valid = 4'b0000;
    check_issue(0);
    do_grant(4'b1111, 0);
    m_valid = 4'b0000;
    check_issue(0);

    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
